// File: rtl/t_framer_if.sv
`default_nettype none
// ============================================================================
// t_framer_if : word handshake and serial-line bundle for the t_framer block
// Rev 1.0
// ============================================================================
interface t_framer_if;
  logic [11:0] data_in;
  logic        valid_in;
  logic        ready_out;
  logic        data_out;
  logic        frame_start;
  logic        busy;
  logic [7:0]  frames_sent;

  modport master (
    output data_in, valid_in,
    input  ready_out, data_out, frame_start, busy, frames_sent
  );

  modport slave (
    input  data_in, valid_in,
    output ready_out, data_out, frame_start, busy, frames_sent
  );
endinterface
`default_nettype wire

// File: rtl/t_framer.sv
`default_nettype none
// ============================================================================
// t_framer : serial frame transmitter, {SYNC, payload} 16-bit frames MSB first
// Rev 1.0
// ============================================================================
module t_framer #(
  parameter logic [3:0] SYNC     = 4'b1110,
  parameter logic       IDLE_BIT = 1'b0
) (
  input  wire logic clk,
  input  wire logic rst,
  t_framer_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic [15:0] shift_q, shift_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  frames_q, frames_d;
  logic        ready_q, ready_d;
  logic        data_out_q, data_out_d;
  logic        frame_start_q, frame_start_d;
  logic        busy_q, busy_d;

  logic        w_accept;
  logic        w_frame_end;
  logic        w_load;

  assign w_accept    = bus.valid_in && ready_q;
  assign w_frame_end = (state_q == ST_SEND) && (bit_cnt_q == 4'd0);
  // A load always consumes the old hold_q; a same-edge accept refills it.
  assign w_load      = hold_full_q && ((state_q == ST_IDLE) || w_frame_end);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      hold_q        <= 12'd0;
      hold_full_q   <= 1'b0;
      shift_q       <= 16'd0;
      bit_cnt_q     <= 4'd0;
      frames_q      <= 8'd0;
      ready_q       <= 1'b0;
      data_out_q    <= IDLE_BIT;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      frames_q      <= frames_d;
      ready_q       <= ready_d;
      data_out_q    <= data_out_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    frames_d      = frames_q;

    if (w_accept) begin
      hold_d = bus.data_in;
    end
    hold_full_d = w_accept || (hold_full_q && !w_load);

    case (state_q)
      ST_IDLE: begin
        if (w_load) begin
          shift_d   = {SYNC, hold_q};
          bit_cnt_d = 4'd15;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (w_frame_end) begin
          frames_d = frames_q + 8'd1;
          if (w_load) begin
            shift_d   = {SYNC, hold_q};
            bit_cnt_d = 4'd15;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          shift_d   = {shift_q[14:0], 1'b0};
          bit_cnt_d = bit_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Line outputs are registered from the next state so they align with shift_q.
    ready_d       = !hold_full_d;
    frame_start_d = w_load;
    busy_d        = (state_d == ST_SEND);
    data_out_d    = (state_d == ST_SEND) ? shift_d[15] : IDLE_BIT;
  end

  assign bus.ready_out   = ready_q;
  assign bus.data_out    = data_out_q;
  assign bus.frame_start = frame_start_q;
  assign bus.busy        = busy_q;
  assign bus.frames_sent = frames_q;

endmodule
`default_nettype wire

// File: tb/tb_t_framer.sv
`default_nettype none
// tb_t_framer : directed self-checking bench for the t_framer serial transmitter
module tb_t_framer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  t_framer_if bus ();

  t_framer u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] frm(input logic [11:0] p);
    return {4'hE, p};
  endfunction

  task automatic wait_ready();
    int t = 0;
    while (!bus.ready_out && t < 64) begin
      tick();
      t++;
    end
    if (!bus.ready_out) check_eq("ready_timeout", {31'd0, bus.ready_out}, 32'd1);
  endtask

  // Drives n words (valid held high with changing data when hold_valid is set,
  // otherwise offered only while ready_out is high) and checks every frame seen.
  task automatic run_stream(input int n, input bit hold_valid, input logic [11:0] seed,
                            input logic [7:0] base);
    logic [11:0] q[$];
    logic [11:0] w;
    logic [15:0] sh;
    int acc = 0;
    int got = 0;
    int nb  = 0;
    int cyc = 0;
    sh = '0;
    while (got < n && cyc < n * 20 + 100) begin
      if (bus.frame_start) begin
        check_eq("stream_cnt", {24'd0, bus.frames_sent}, {24'd0, base + 8'(got)});
        nb = 16;
        sh = '0;
      end
      if (nb > 0) begin
        sh = {sh[14:0], bus.data_out};
        nb--;
        if (nb == 0) begin
          w = (q.size() > 0) ? q.pop_front() : 12'hxxx;
          check_eq("stream_frame", {16'd0, sh}, {16'd0, frm(w)});
          got++;
        end
      end
      if (acc < n && (hold_valid || bus.ready_out)) begin
        bus.valid_in = 1'b1;
        bus.data_in  = seed + 12'(cyc * 5);
        if (bus.ready_out) begin
          q.push_back(bus.data_in);
          acc++;
        end
      end else begin
        bus.valid_in = 1'b0;
      end
      tick();
      cyc++;
    end
    bus.valid_in = 1'b0;
    if (got < n) check_eq("stream_timeout", got, n);
    check_eq("stream_leftover", q.size(), 0);
  endtask

  initial begin
    logic [15:0] pat;
    logic [47:0] exp48;
    bit          noisy;

    bus.data_in  = '0;
    bus.valid_in = 1'b0;

    // Reset state
    #20;
    check_eq("rst_data_out", {31'd0, bus.data_out}, 32'd0);
    check_eq("rst_ready", {31'd0, bus.ready_out}, 32'd0);
    check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("rst_fs", {31'd0, bus.frame_start}, 32'd0);
    check_eq("rst_frames", {24'd0, bus.frames_sent}, 32'd0);
    #2 rst = 1'b1;
    tick();
    check_eq("ready_after_rst", {31'd0, bus.ready_out}, 32'd1);

    // Single word
    bus.valid_in = 1'b1;
    bus.data_in  = 12'hABC;
    tick();
    bus.valid_in = 1'b0;
    check_eq("single_ready_drop", {31'd0, bus.ready_out}, 32'd0);
    check_eq("single_pre_line", {31'd0, bus.data_out}, 32'd0);
    pat = 16'hEABC;
    for (int i = 15; i >= 0; i--) begin
      tick();
      check_eq("single_bit", {31'd0, bus.data_out}, {31'd0, pat[i]});
      check_eq("single_fs", {31'd0, bus.frame_start}, (i == 15) ? 32'd1 : 32'd0);
      check_eq("single_busy", {31'd0, bus.busy}, 32'd1);
      if (i == 15) check_eq("single_ready_back", {31'd0, bus.ready_out}, 32'd1);
    end
    tick();
    check_eq("single_end_line", {31'd0, bus.data_out}, 32'd0);
    check_eq("single_end_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("single_end_cnt", {24'd0, bus.frames_sent}, 32'd1);

    // Back-to-back
    exp48 = {16'hE001, 16'hE002, 16'hE003};
    fork
      begin
        for (int w = 1; w <= 3; w++) begin
          wait_ready();
          bus.valid_in = 1'b1;
          bus.data_in  = 12'(w);
          tick();
          bus.valid_in = 1'b0;
        end
      end
      begin
        int t = 0;
        while (!bus.frame_start && t < 40) begin
          tick();
          t++;
        end
        check_eq("b2b_start", {31'd0, bus.frame_start}, 32'd1);
        for (int b = 0; b < 48; b++) begin
          check_eq("b2b_bit", {31'd0, bus.data_out}, {31'd0, exp48[47 - b]});
          check_eq("b2b_fs", {31'd0, bus.frame_start}, (b % 16 == 0) ? 32'd1 : 32'd0);
          check_eq("b2b_busy", {31'd0, bus.busy}, 32'd1);
          tick();
        end
        check_eq("b2b_end_busy", {31'd0, bus.busy}, 32'd0);
        check_eq("b2b_end_line", {31'd0, bus.data_out}, 32'd0);
        check_eq("b2b_end_cnt", {24'd0, bus.frames_sent}, 32'd4);
      end
    join

    // Backpressure: valid held high with changing data
    run_stream(5, 1'b1, 12'h300, 8'd4);
    tick();
    check_eq("bp_cnt", {24'd0, bus.frames_sent}, 32'd9);
    check_eq("bp_busy", {31'd0, bus.busy}, 32'd0);

    // Reset at bit 7 of 12'h5A5 with 12'h111 held
    wait_ready();
    bus.valid_in = 1'b1;
    bus.data_in  = 12'h5A5;
    tick();
    bus.valid_in = 1'b0;
    tick();
    check_eq("mid_fs", {31'd0, bus.frame_start}, 32'd1);
    bus.valid_in = 1'b1;
    bus.data_in  = 12'h111;
    tick();
    bus.valid_in = 1'b0;
    check_eq("mid_held", {31'd0, bus.ready_out}, 32'd0);
    repeat (7) tick();
    check_eq("mid_bit7", {31'd0, bus.data_out}, 32'd1);
    #1 rst = 1'b0;
    #1;
    check_eq("mid_rst_line", {31'd0, bus.data_out}, 32'd0);
    check_eq("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("mid_rst_ready", {31'd0, bus.ready_out}, 32'd0);
    check_eq("mid_rst_cnt", {24'd0, bus.frames_sent}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check_eq("mid_rel_ready", {31'd0, bus.ready_out}, 32'd1);
    noisy = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus.busy || bus.data_out || bus.frame_start) noisy = 1'b1;
      tick();
    end
    check_eq("mid_quiet", {31'd0, noisy}, 32'd0);
    check_eq("mid_quiet_cnt", {24'd0, bus.frames_sent}, 32'd0);

    // Counter wrap after 256 frames
    run_stream(256, 1'b0, 12'h0A5, 8'd0);
    tick();
    check_eq("wrap_cnt", {24'd0, bus.frames_sent}, 32'd0);
    check_eq("wrap_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("wrap_line", {31'd0, bus.data_out}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
